// File: rtl/rst_seq_core.sv
// -----------------------------------------------------------------------------
// rst_seq_core
//
// Staged reset sequencer for the core clock domain. Synchronises the PLL lock
// flag and the board reset button, debounces the button, then releases the
// memory, core and peripheral resets in that order with programmable gaps.
// Any lock loss or debounced button press re-asserts all three resets at once.
// The cause of the last reset and a saturating lock-loss count are kept for
// debug.
//
// Ports:
//   i_clk            core clock
//   i_rst_n          asynchronous active-low reset
//   i_pll_locked     PLL lock flag (asynchronous to i_clk)
//   i_btn_rst        board reset button, active-high, asynchronous, bouncing
//   o_rst_mem        memory-domain reset, active-high
//   o_rst_core       CPU-core reset, active-high
//   o_rst_periph     peripheral reset, active-high
//   o_ready          high only once every domain has been released
//   o_reset_cause    00 power-on / i_rst_n, 01 lock loss, 10 button
//   o_lock_loss_cnt  number of lock-loss events, saturating at 255
// -----------------------------------------------------------------------------
module rst_seq_core #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 125000,
    parameter int STAGE1_DELAY    = 16,
    parameter int STAGE2_DELAY    = 256,
    parameter int CNT_W           = 17
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pll_locked,
    input  logic       i_btn_rst,
    output logic       o_rst_mem,
    output logic       o_rst_core,
    output logic       o_rst_periph,
    output logic       o_ready,
    output logic [1:0] o_reset_cause,
    output logic [7:0] o_lock_loss_cnt
);

    localparam logic [2:0] ST_WAIT_LOCK  = 3'd0;
    localparam logic [2:0] ST_REL_MEM    = 3'd1;
    localparam logic [2:0] ST_REL_CORE   = 3'd2;
    localparam logic [2:0] ST_REL_PERIPH = 3'd3;
    localparam logic [2:0] ST_RUN        = 3'd4;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_BTN  = 2'b10;

    // Counters count down to zero, so a delay of N cycles loads N-1.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] S1_LOAD = CNT_W'(STAGE1_DELAY - 1);
    localparam logic [CNT_W-1:0] S2_LOAD = CNT_W'(STAGE2_DELAY - 1);

    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
    logic                   locked_s, btn_s;

    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             btn_db_q, btn_db_d;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic             rst_mem_q, rst_mem_d;
    logic             rst_core_q, rst_core_d;
    logic             rst_periph_q, rst_periph_d;
    logic             ready_q, ready_d;
    logic [1:0]       cause_q, cause_d;

    logic             locked_prev_q, locked_prev_d;
    logic [7:0]       loss_cnt_q, loss_cnt_d;

    logic             fault;

    // Input synchronisers: shift each asynchronous input through its own chain.
    always_comb begin
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], i_pll_locked};
        btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], i_btn_rst};
    end

    assign locked_s = lock_sync_q[SYNC_STAGES-1];
    assign btn_s    = btn_sync_q[SYNC_STAGES-1];

    // Debounce: the filtered button only flips once the synchronised button has
    // disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any agreeing
    // cycle restarts the count.
    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (btn_s != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = ~btn_db_q;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
    end

    assign fault = ~locked_s | btn_db_q;

    // Sequencer: faults outside WAIT_LOCK take priority over any pending
    // release so all three resets re-assert together on the same edge.
    always_comb begin
        state_d      = state_q;
        dly_d        = dly_q;
        rst_mem_d    = rst_mem_q;
        rst_core_d   = rst_core_q;
        rst_periph_d = rst_periph_q;
        ready_d      = ready_q;
        cause_d      = cause_q;

        if ((state_q != ST_WAIT_LOCK) && fault) begin
            state_d      = ST_WAIT_LOCK;
            dly_d        = '0;
            rst_mem_d    = 1'b1;
            rst_core_d   = 1'b1;
            rst_periph_d = 1'b1;
            ready_d      = 1'b0;
            // Lock loss wins when both fault sources are present.
            cause_d      = locked_s ? CAUSE_BTN : CAUSE_LOCK;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    rst_mem_d    = 1'b1;
                    rst_core_d   = 1'b1;
                    rst_periph_d = 1'b1;
                    ready_d      = 1'b0;
                    if (!fault) begin
                        state_d = ST_REL_MEM;
                        dly_d   = S1_LOAD;
                    end
                end
                ST_REL_MEM: begin
                    if (dly_q == '0) begin
                        rst_mem_d = 1'b0;
                        state_d   = ST_REL_CORE;
                        dly_d     = S2_LOAD;
                    end else begin
                        dly_d = dly_q - CNT_W'(1);
                    end
                end
                ST_REL_CORE: begin
                    if (dly_q == '0) begin
                        rst_core_d = 1'b0;
                        state_d    = ST_REL_PERIPH;
                        dly_d      = S1_LOAD;
                    end else begin
                        dly_d = dly_q - CNT_W'(1);
                    end
                end
                ST_REL_PERIPH: begin
                    if (dly_q == '0) begin
                        rst_periph_d = 1'b0;
                        ready_d      = 1'b1;
                        state_d      = ST_RUN;
                    end else begin
                        dly_d = dly_q - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d      = ST_WAIT_LOCK;
                    dly_d        = '0;
                    rst_mem_d    = 1'b1;
                    rst_core_d   = 1'b1;
                    rst_periph_d = 1'b1;
                    ready_d      = 1'b0;
                end
            endcase
        end
    end

    // Lock-loss counter: counts falling edges of the synchronised lock flag in
    // every state, holding at 255.
    always_comb begin
        locked_prev_d = locked_s;
        loss_cnt_d    = loss_cnt_q;
        if (locked_prev_q && !locked_s && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_sync_q   <= '0;
            btn_sync_q    <= '0;
            db_cnt_q      <= '0;
            btn_db_q      <= 1'b0;
            state_q       <= ST_WAIT_LOCK;
            dly_q         <= '0;
            rst_mem_q     <= 1'b1;
            rst_core_q    <= 1'b1;
            rst_periph_q  <= 1'b1;
            ready_q       <= 1'b0;
            cause_q       <= CAUSE_POR;
            locked_prev_q <= 1'b0;
            loss_cnt_q    <= '0;
        end else begin
            lock_sync_q   <= lock_sync_d;
            btn_sync_q    <= btn_sync_d;
            db_cnt_q      <= db_cnt_d;
            btn_db_q      <= btn_db_d;
            state_q       <= state_d;
            dly_q         <= dly_d;
            rst_mem_q     <= rst_mem_d;
            rst_core_q    <= rst_core_d;
            rst_periph_q  <= rst_periph_d;
            ready_q       <= ready_d;
            cause_q       <= cause_d;
            locked_prev_q <= locked_prev_d;
            loss_cnt_q    <= loss_cnt_d;
        end
    end

    assign o_rst_mem       = rst_mem_q;
    assign o_rst_core      = rst_core_q;
    assign o_rst_periph    = rst_periph_q;
    assign o_ready         = ready_q;
    assign o_reset_cause   = cause_q;
    assign o_lock_loss_cnt = loss_cnt_q;

endmodule
